// File: rtl/tdm_demux_1_4_pkg.sv
// ============================================================================
// Module  : tdm_demux_1_4_pkg
// Brief   : State encoding and slot constants for the 1:4 TDM demultiplexer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_demux_1_4_pkg;

    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_WIDTH = 2;

    typedef enum logic {
        STATE_HUNT   = 1'b0,
        STATE_LOCKED = 1'b1
    } state_t;

    typedef logic [SLOT_WIDTH-1:0] slot_t;

    localparam slot_t SLOT_0 = 2'd0;
    localparam slot_t SLOT_1 = 2'd1;
    localparam slot_t SLOT_2 = 2'd2;
    localparam slot_t SLOT_3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tdm_demux_1_4.sv
// ============================================================================
// Module  : tdm_demux_1_4
// Brief   : Receive-side 1:4 TDM demux; locks on slot-0 sync and publishes
//           all four channels together once per complete frame.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux_1_4
    import tdm_demux_1_4_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  Clock_In,
    input  logic                  Reset_N_In,
    input  logic                  Enable_In,
    input  logic                  Data_Valid_In,
    input  logic                  Frame_Sync_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic [DATA_WIDTH-1:0] Data_0_Out,
    output logic [DATA_WIDTH-1:0] Data_1_Out,
    output logic [DATA_WIDTH-1:0] Data_2_Out,
    output logic [DATA_WIDTH-1:0] Data_3_Out,
    output logic                  Frame_Valid_Out,
    output logic                  Locked_Out,
    output logic [SLOT_WIDTH-1:0] Slot_Out,
    output logic                  Sync_Error_Out
);

    state_t                state_q, state_d;
    slot_t                 slot_q, slot_d;
    logic [DATA_WIDTH-1:0] shadow0_q, shadow0_d;
    logic [DATA_WIDTH-1:0] shadow1_q, shadow1_d;
    logic [DATA_WIDTH-1:0] shadow2_q, shadow2_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [DATA_WIDTH-1:0] data3_q, data3_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  sync_err_q, sync_err_d;
    logic                  accept_w;

    assign accept_w = Enable_In && Data_Valid_In;

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q       <= STATE_HUNT;
            slot_q        <= SLOT_0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            data3_q       <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            data3_q       <= data3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        data0_d       = data0_q;
        data1_d       = data1_q;
        data2_d       = data2_q;
        data3_d       = data3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = sync_err_q;

        if (accept_w) begin
            case (state_q)
                STATE_HUNT: begin
                    if (Frame_Sync_In) begin
                        shadow0_d = Data_In;
                        slot_d    = SLOT_1;
                        state_d   = STATE_LOCKED;
                    end
                end
                default: begin
                    if (Frame_Sync_In) begin
                        // A sync anywhere but slot 0 drops the partial frame and restarts it.
                        if (slot_q != SLOT_0) begin
                            sync_err_d = 1'b1;
                        end
                        shadow0_d = Data_In;
                        slot_d    = SLOT_1;
                    end else begin
                        case (slot_q)
                            SLOT_0: begin
                                sync_err_d = 1'b1;
                                state_d    = STATE_HUNT;
                            end
                            SLOT_1: begin
                                shadow1_d = Data_In;
                                slot_d    = SLOT_2;
                            end
                            SLOT_2: begin
                                shadow2_d = Data_In;
                                slot_d    = SLOT_3;
                            end
                            default: begin
                                data0_d       = shadow0_q;
                                data1_d       = shadow1_q;
                                data2_d       = shadow2_q;
                                data3_d       = Data_In;
                                frame_valid_d = 1'b1;
                                slot_d        = SLOT_0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign Data_0_Out      = data0_q;
    assign Data_1_Out      = data1_q;
    assign Data_2_Out      = data2_q;
    assign Data_3_Out      = data3_q;
    assign Frame_Valid_Out = frame_valid_q;
    assign Locked_Out      = (state_q == STATE_LOCKED);
    assign Slot_Out        = slot_q;
    assign Sync_Error_Out  = sync_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1_4.sv
// ============================================================================
// Module  : tb_tdm_demux_1_4
// Brief   : Scoreboard bench for tdm_demux_1_4 with DATA_WIDTH=8.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_1_4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       vld;
    logic       sync;
    logic [7:0] din;
    logic [7:0] d0, d1, d2, d3;
    logic       fv;
    logic       locked;
    logic [1:0] slot;
    logic       serr;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_q [$];

    tdm_demux_1_4 #(.DATA_WIDTH(8)) dut (
        .Clock_In        (clk),
        .Reset_N_In      (rst_n),
        .Enable_In       (en),
        .Data_Valid_In   (vld),
        .Frame_Sync_In   (sync),
        .Data_In         (din),
        .Data_0_Out      (d0),
        .Data_1_Out      (d1),
        .Data_2_Out      (d2),
        .Data_3_Out      (d3),
        .Frame_Valid_Out (fv),
        .Locked_Out      (locked),
        .Slot_Out        (slot),
        .Sync_Error_Out  (serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every frame pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && fv === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {d0, d1, d2, d3}, 32'hxxxxxxxx);
            end else begin
                chk("frame_data", {d0, d1, d2, d3}, exp_q.pop_front());
            end
        end
    end

    task automatic beat(input logic s, input logic [7:0] d);
        @(negedge clk);
        en = 1'b1; vld = 1'b1; sync = s; din = d;
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0; sync = 1'b0; din = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vld = 1'b0; sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame(input logic [31:0] f);
        exp_q.push_back(f);
        beat(1'b1, f[31:24]);
        beat(1'b0, f[23:16]);
        beat(1'b0, f[15:8]);
        beat(1'b0, f[7:0]);
        idle();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; en = 1'b0; vld = 1'b0; sync = 1'b0; din = 8'h00;
        #1;
        chk("reset_data", {d0, d1, d2, d3}, 32'h0);
        chk("reset_flags", {29'd0, fv, locked, serr}, 32'h0);
        chk("reset_slot", {30'd0, slot}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame
        frame(32'h11223344);
        chk("t1_locked", {31'd0, locked}, 32'h1);
        chk("t1_slot", {30'd0, slot}, 32'h0);
        chk("t1_serr", {31'd0, serr}, 32'h0);
        idle();
        chk("t1_pulse_once", {31'd0, fv}, 32'h0);

        // Unsynced beats ignored in HUNT
        do_reset();
        beat(1'b0, 8'hAA);
        beat(1'b0, 8'hBB);
        idle();
        chk("t2_hunt_locked", {31'd0, locked}, 32'h0);
        chk("t2_hunt_slot", {30'd0, slot}, 32'h0);
        frame(32'h01020304);
        chk("t2_data", {d0, d1, d2, d3}, 32'h01020304);

        // Early sync at slot 2
        beat(1'b1, 8'hA1);
        beat(1'b0, 8'hA2);
        exp_q.push_back(32'h55667788);
        beat(1'b1, 8'h55);
        idle();
        chk("t3_serr", {31'd0, serr}, 32'h1);
        chk("t3_slot", {30'd0, slot}, 32'h1);
        chk("t3_locked", {31'd0, locked}, 32'h1);
        chk("t3_held", {d0, d1, d2, d3}, 32'h01020304);
        beat(1'b0, 8'h66);
        beat(1'b0, 8'h77);
        beat(1'b0, 8'h88);
        idle();
        chk("t3_data", {d0, d1, d2, d3}, 32'h55667788);

        // Lost sync at slot 0
        do_reset();
        frame(32'hC1C2C3C4);
        chk("t4_serr_before", {31'd0, serr}, 32'h0);
        beat(1'b0, 8'h99);
        idle();
        chk("t4_serr", {31'd0, serr}, 32'h1);
        chk("t4_locked", {31'd0, locked}, 32'h0);
        chk("t4_held", {d0, d1, d2, d3}, 32'hC1C2C3C4);

        // Enable low mid-frame with garbage on the lane
        exp_q.push_back(32'hD1D2D3D4);
        beat(1'b1, 8'hD1);
        beat(1'b0, 8'hD2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0; vld = 1'b1; sync = i[0]; din = 8'hE0 + 8'(i);
            chk("t5_slot_frozen", {30'd0, slot}, 32'h2);
        end
        beat(1'b0, 8'hD3);
        beat(1'b0, 8'hD4);
        idle();
        chk("t5_data", {d0, d1, d2, d3}, 32'hD1D2D3D4);

        // Async reset mid-frame at slot 2
        beat(1'b1, 8'hE1);
        beat(1'b0, 8'hE2);
        idle();
        chk("t6_slot_pre", {30'd0, slot}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_data", {d0, d1, d2, d3}, 32'h0);
        chk("t6_rst_flags", {29'd0, fv, locked, serr}, 32'h0);
        chk("t6_rst_slot", {30'd0, slot}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(32'hF1F2F3F4);
        chk("t6_data", {d0, d1, d2, d3}, 32'hF1F2F3F4);

        repeat (4) idle();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux_1_4.md
Name: tdm_demux_1_4

Overview:
- Time-division 1:4 demultiplexer: the receive end of the 4:1 channel-multiplexed link. The transmit side scans Data_0..Data_3 onto one shared lane, one slot per valid beat.
- Recovers frame alignment from a slot-0 sync marker and distributes the four slots into four registered channel outputs. All four outputs update together once per complete frame.
- Sits between the shared serial/TDM lane and the per-channel consumers.

Parameters:
- DATA_WIDTH, 1, width of each slot word and of each channel output.

Ports:
- Clock_In  input  1  single clock; all state updates on rising edge.
- Reset_N_In  input  1  asynchronous, active-low reset.
- Enable_In  input  1  block enable; when low, beats are ignored and all state is held.
- Data_Valid_In  input  1  qualifies Data_In and Frame_Sync_In for this cycle (one beat).
- Frame_Sync_In  input  1  high on the beat carrying slot 0.
- Data_In  input  DATA_WIDTH  slot word on the shared lane.
- Data_0_Out  output  DATA_WIDTH  channel 0 word of the last complete frame.
- Data_1_Out  output  DATA_WIDTH  channel 1 word of the last complete frame.
- Data_2_Out  output  DATA_WIDTH  channel 2 word of the last complete frame.
- Data_3_Out  output  DATA_WIDTH  channel 3 word of the last complete frame.
- Frame_Valid_Out  output  1  one-cycle pulse; Data_x_Out have just been updated.
- Locked_Out  output  1  high while in the LOCKED state.
- Slot_Out  output  2  slot index expected on the next beat.
- Sync_Error_Out  output  1  sticky alignment-error flag.

Behaviour:
- Accepted beat: Enable_In=1 and Data_Valid_In=1 on a rising edge. All other cycles hold all state. Frame_Valid_Out is 0 on non-completing cycles.
- Reset (async assert, sync-free deassert):
  - state=HUNT, slot=0, shadow regs=0.
  - Data_0..3_Out=0, Frame_Valid_Out=0, Locked_Out=0, Slot_Out=0, Sync_Error_Out=0.
- HUNT state:
  - An accepted beat with Frame_Sync_In=0 is discarded.
  - An accepted beat with Frame_Sync_In=1: shadow0<=Data_In, slot<=1, go to LOCKED.
- LOCKED state, accepted beat, slot 1..2, Frame_Sync_In=0: shadow[slot]<=Data_In, slot<=slot+1.
- LOCKED state, accepted beat, slot 3, Frame_Sync_In=0 (frame completion):
  - Data_0..2_Out<=shadow0..2 and Data_3_Out<=Data_In, all on the same edge.
  - Frame_Valid_Out<=1 for exactly that next cycle.
  - slot wraps to 0.
- LOCKED state, accepted beat, slot 0, Frame_Sync_In=1: normal start of frame; shadow0<=Data_In, slot<=1.
- LOCKED state, accepted beat, slot 0, Frame_Sync_In=0 (lost sync):
  - Beat discarded; Sync_Error_Out<=1; go to HUNT.
- LOCKED state, accepted beat, slot 1..3, Frame_Sync_In=1 (early sync):
  - Partial frame discarded; outputs are not updated.
  - Sync_Error_Out<=1.
  - Beat treated as slot 0: shadow0<=Data_In, slot<=1, remain LOCKED.
- Sync_Error_Out is cleared only by reset.
- Enable_In low mid-frame: slot and shadows are frozen; the frame resumes at the same slot when Enable_In returns high.
- Latency: Data_x_Out and Frame_Valid_Out are valid in the cycle after the edge that accepts slot 3.
- Throughput: one complete frame per 4 consecutive accepted beats; back-to-back frames are supported with no gap.
- Locked_Out and Slot_Out are registered views of the state and slot counter.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state encoding constants STATE_HUNT=1'b0, STATE_LOCKED=1'b1;
  - NUM_SLOTS=4 and SLOT_WIDTH=2;
  - slot index constants SLOT_0..SLOT_3.
- Single module; no sub-module. The counter and FSM are too small to warrant splitting.

Test Plan (DATA_WIDTH=8):
- Reset, then 4 contiguous accepted beats with sync on the first, data 0x11,0x22,0x33,0x44 -> next cycle Data_0..3_Out=0x11/0x22/0x33/0x44, Frame_Valid_Out pulses once, Locked_Out=1, Slot_Out=0.
- In HUNT, beats 0xAA,0xBB without sync, then a synced frame 0x01..0x04 -> first two beats ignored; outputs 0x01..0x04; one Frame_Valid_Out pulse.
- Locked; sync asserted at slot 2 with 0x55, followed by 0x66,0x77,0x88 -> Sync_Error_Out=1, no pulse for the partial frame, then outputs 0x55/0x66/0x77/0x88 with one pulse.
- Locked; beat at slot 0 without sync -> Sync_Error_Out=1, Locked_Out=0, previous outputs unchanged.
- Enable_In low for 3 cycles between slot 1 and slot 2, with Data_Valid_In=1 and garbage data -> garbage ignored; frame completes correctly after re-enable.
- Async reset asserted mid-frame at slot 2 -> all outputs 0 immediately, HUNT state; a new synced frame then decodes correctly.
